// File: rtl/bn_pkg.sv
// Shared definitions for the batch-norm channel sequencer.
//   state_t     : sequencer FSM states
//   BN_ONE      : 1.0 in the default Q4.12 format
//   param_field : extracts one field of the packed {gamma,beta,mean,std} word
package bn_pkg;

    localparam int BN_DW     = 16;
    localparam int BN_FRAC   = 12;
    localparam int BN_ONE    = 1 << BN_FRAC;
    localparam int BN_MAX_W  = 32;
    localparam int BN_WORD_W = 4 * BN_MAX_W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PFETCH,
        S_PLATCH,
        S_WAIT_IN,
        S_ISSUE,
        S_WAIT_RDY,
        S_FEED,
        S_WAIT_DONE,
        S_EMIT,
        S_FINISH
    } state_t;

    // Field index counts from the LSB end of the packed word.
    typedef enum logic [1:0] {
        F_STD   = 2'd0,
        F_MEAN  = 2'd1,
        F_BETA  = 2'd2,
        F_GAMMA = 2'd3
    } param_field_e;

    // The word is zero-extended to BN_WORD_W so one function serves any
    // sample width up to BN_MAX_W; the caller truncates the result.
    function automatic logic [BN_MAX_W-1:0] param_field(
        input logic [BN_WORD_W-1:0] word,
        input int unsigned          dw,
        input param_field_e         f
    );
        logic [BN_WORD_W-1:0] sh;
        logic [BN_MAX_W-1:0]  mask;
        sh   = word >> (dw * 32'(f));
        mask = (dw >= BN_MAX_W) ? '1 : ((BN_MAX_W'(1) << dw) - BN_MAX_W'(1));
        return sh[BN_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/bn_channel_sequencer.sv
// Sequences one shared batch-norm engine over NUM_CH channels of PIX_PER_CH
// pixels. Per channel it reads the packed {gamma,beta,mean,std} word, then
// pops pixels from a FWFT FIFO one at a time, handshakes each through the
// engine (enable/ready, read_flag/done) and presents the result downstream
// with valid/ready backpressure. Samples are passed through untouched.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start / busy / run_done  run control and status
//   err_timeout/err_std_zero sticky error flags, cleared by start
//   in_empty/in_data/in_rd   FWFT input FIFO
//   param_rd_en/addr/rdata   parameter memory, 1-cycle read latency
//   bn_*                     engine handshake, held sample and parameters
//   out_valid/ready/data/ch/last  result stream
module bn_channel_sequencer
    import bn_pkg::*;
#(
    parameter int  DATA_WIDTH  = BN_DW,
    parameter int  FRAC_SZ     = BN_FRAC,
    parameter int  NUM_CH      = 8,
    parameter int  PIX_PER_CH  = 64,
    parameter int  TIMEOUT_CYC = 64,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    run_done,
    output logic                    err_timeout,
    output logic                    err_std_zero,
    input  logic                    in_empty,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_rd,
    output logic                    param_rd_en,
    output logic [CH_W-1:0]         param_addr,
    input  logic [4*DATA_WIDTH-1:0] param_rdata,
    output logic                    bn_enable,
    input  logic                    bn_ready,
    output logic                    bn_read_flag,
    output logic [DATA_WIDTH-1:0]   bn_input,
    output logic [DATA_WIDTH-1:0]   bn_mean,
    output logic [DATA_WIDTH-1:0]   bn_std,
    output logic [DATA_WIDTH-1:0]   bn_gamma,
    output logic [DATA_WIDTH-1:0]   bn_beta,
    input  logic                    bn_done,
    input  logic [DATA_WIDTH-1:0]   bn_output,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [CH_W-1:0]         out_ch,
    output logic                    out_last
);

    localparam int PIX_W = (PIX_PER_CH > 1) ? $clog2(PIX_PER_CH) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1) << FRAC_SZ;
    localparam logic [CH_W-1:0]       CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [PIX_W-1:0]      PIX_LAST = PIX_W'(PIX_PER_CH - 1);
    localparam logic [WD_W-1:0]       WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

    state_t               state, state_n;
    logic [CH_W-1:0]      ch;
    logic [PIX_W-1:0]     pix;
    logic [WD_W-1:0]      wd_cnt;
    logic                 wd_expired;
    logic                 timeout_hit;
    logic                 pix_last;
    logic                 ch_last;
    logic [BN_WORD_W-1:0] pword;
    logic [DATA_WIDTH-1:0] std_f;

    assign pword      = BN_WORD_W'(param_rdata);
    assign std_f      = DATA_WIDTH'(param_field(pword, DATA_WIDTH, F_STD));
    assign param_addr = ch;
    assign pix_last   = (pix == PIX_LAST);
    assign ch_last    = (ch == CH_LAST);
    assign wd_expired = (wd_cnt >= WD_LIMIT);

    // A result arriving on the expiry cycle takes priority over the abort.
    assign timeout_hit = wd_expired &&
                         (((state == S_WAIT_RDY) && !bn_ready) ||
                          ((state == S_WAIT_DONE) && !bn_done));

    always_comb begin
        state_n      = state;
        in_rd        = 1'b0;
        param_rd_en  = (state == S_PFETCH);
        bn_enable    = (state == S_ISSUE);
        bn_read_flag = (state == S_FEED) || (state == S_WAIT_DONE);
        out_valid    = (state == S_EMIT);
        run_done     = (state == S_FINISH);
        busy         = (state != S_IDLE);
        case (state)
            S_IDLE:      if (start) state_n = S_PFETCH;
            S_PFETCH:    state_n = S_PLATCH;
            S_PLATCH:    state_n = S_WAIT_IN;
            S_WAIT_IN: begin
                if (!in_empty) begin
                    in_rd   = 1'b1;
                    state_n = S_ISSUE;
                end
            end
            S_ISSUE:     state_n = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (bn_ready)         state_n = S_FEED;
                else if (timeout_hit) state_n = S_FINISH;
            end
            S_FEED:      state_n = bn_done ? S_EMIT : S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (bn_done)          state_n = S_EMIT;
                else if (timeout_hit) state_n = S_FINISH;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (!pix_last)     state_n = S_WAIT_IN;
                    else if (!ch_last) state_n = S_PFETCH;
                    else               state_n = S_FINISH;
                end
            end
            S_FINISH:    state_n = S_IDLE;
            default:     state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            ch           <= '0;
            pix          <= '0;
            wd_cnt       <= '0;
            err_timeout  <= 1'b0;
            err_std_zero <= 1'b0;
            bn_input     <= '0;
            bn_mean      <= '0;
            bn_std       <= ONE;
            bn_gamma     <= '0;
            bn_beta      <= '0;
            out_data     <= '0;
            out_ch       <= '0;
            out_last     <= 1'b0;
        end else begin
            state <= state_n;
            // Watchdog restarts on every state change and saturates at the limit.
            if (state_n != state)  wd_cnt <= '0;
            else if (!wd_expired)  wd_cnt <= wd_cnt + WD_W'(1);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        ch           <= '0;
                        pix          <= '0;
                        err_timeout  <= 1'b0;
                        err_std_zero <= 1'b0;
                    end
                end
                S_PLATCH: begin
                    bn_gamma <= DATA_WIDTH'(param_field(pword, DATA_WIDTH, F_GAMMA));
                    bn_beta  <= DATA_WIDTH'(param_field(pword, DATA_WIDTH, F_BETA));
                    bn_mean  <= DATA_WIDTH'(param_field(pword, DATA_WIDTH, F_MEAN));
                    // A zero std would divide by zero in the engine; use 1.0.
                    if (std_f == '0) begin
                        bn_std       <= ONE;
                        err_std_zero <= 1'b1;
                    end else begin
                        bn_std <= std_f;
                    end
                end
                S_WAIT_IN: begin
                    if (!in_empty) bn_input <= in_data;
                end
                S_WAIT_RDY: begin
                    if (timeout_hit) err_timeout <= 1'b1;
                end
                S_FEED, S_WAIT_DONE: begin
                    if (bn_done) begin
                        out_data <= bn_output;
                        out_ch   <= ch;
                        out_last <= pix_last;
                    end else if (timeout_hit) begin
                        err_timeout <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (!pix_last) begin
                            pix <= pix + PIX_W'(1);
                        end else begin
                            pix <= '0;
                            if (!ch_last) ch <= ch + CH_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
